data_memory_for_cache: RTL and testbench

Word-organised data memory that backs the data cache. It accepts byte-masked 32-bit writes and always presents the complete 256-bit cache line (eight words) containing the addressed word, so a cache refill is a single access. It sits below the data cache controller and is the only data store in the memory hierarchy.

---
 rtl/data_memory_for_cache_pkg.sv | 22 ++
 rtl/data_memory_for_cache.sv | 63 ++++++
 tb/tb_data_memory_for_cache.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/data_memory_for_cache_pkg.sv
// Shared geometry of the cache-backing data memory: word/line sizes and the
// byte-address fields used to select a word and its enclosing line.
package data_memory_for_cache_pkg;

   localparam int WORD_BITS      = 32;
   localparam int BYTE_BITS      = 8;
   localparam int BYTES_PER_WORD = 4;
   localparam int WORDS_PER_LINE = 8;
   localparam int LINE_BITS      = WORD_BITS * WORDS_PER_LINE;

   // Byte-address slicing: [1:0] byte-in-word (ignored), [4:2] word-in-line, [31:5] line index.
   localparam int WORD_IN_LINE_LSB = 2;
   localparam int WORD_IN_LINE_MSB = 4;
   localparam int LINE_INDEX_LSB   = 5;
   localparam int LINE_INDEX_MSB   = 31;
   localparam int WORD_IN_LINE_BITS = WORD_IN_LINE_MSB - WORD_IN_LINE_LSB + 1;

   typedef logic [WORD_BITS-1:0]      word_t;
   typedef logic [LINE_BITS-1:0]      line_t;
   typedef logic [BYTES_PER_WORD-1:0] byte_mask_t;

endpackage

// File: rtl/data_memory_for_cache.sv
// Word-organised data memory: byte-masked 32-bit writes, combinational read of
// the full 256-bit line containing the addressed word.
module data_memory_for_cache
   import data_memory_for_cache_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      write_enable,
   input  logic [31:0]               address,
   input  logic [WORD_BITS-1:0]      write_data,
   input  logic [BYTES_PER_WORD-1:0] write_mask,
   output logic [LINE_BITS-1:0]      read_data
);

   localparam int NUM_LINES     = DEPTH_WORDS / WORDS_PER_LINE;
   localparam int LINE_IDX_BITS = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
   localparam int WORD_IDX_BITS = LINE_IDX_BITS + WORD_IN_LINE_BITS;
   localparam int USED_ADDR_MSB = LINE_INDEX_LSB + LINE_IDX_BITS - 1;

   word_t mem [DEPTH_WORDS];

   logic [LINE_IDX_BITS-1:0]     line_idx;
   logic [WORD_IN_LINE_BITS-1:0] word_in_line;
   logic [WORD_IDX_BITS-1:0]     word_idx;

   // Upper bits beyond the depth drop out here, which is what makes the line index wrap.
   assign line_idx     = (NUM_LINES > 1) ? address[LINE_INDEX_LSB +: LINE_IDX_BITS] : '0;
   assign word_in_line = address[WORD_IN_LINE_MSB:WORD_IN_LINE_LSB];
   assign word_idx     = {line_idx, word_in_line};

   logic unused_address_bits;
   assign unused_address_bits = ^{address[LINE_INDEX_MSB:USED_ADDR_MSB+1], address[1:0]};

   function automatic word_t merge_bytes(input word_t old_word, input word_t new_data,
                                         input byte_mask_t mask);
      word_t expanded_mask;
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
         expanded_mask[i*BYTE_BITS +: BYTE_BITS] = {BYTE_BITS{mask[i]}};
      end
      return (old_word & ~expanded_mask) | (new_data & expanded_mask);
   endfunction

   // NOTE: non-blocking assignments keep every update on this edge ordered against
   // the read path; a blocking write here would race with other clocked readers.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: clearing the whole array is a functional requirement (contents must read
         // zero after reset), so this memory is deliberately built from flops, not a RAM macro.
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem[i] <= '0;
         end
      end else if (write_enable) begin
         mem[word_idx] <= merge_bytes(mem[word_idx], write_data, write_mask);
      end
   end

   for (genvar k = 0; k < WORDS_PER_LINE; k++) begin : g_line_word
      assign read_data[k*WORD_BITS +: WORD_BITS] = mem[{line_idx, WORD_IN_LINE_BITS'(k)}];
   end

endmodule

// File: tb/tb_data_memory_for_cache.sv
// Scoreboard bench: stimulus pushes expected lines, a negedge monitor pops and compares.
module tb_data_memory_for_cache;
   import data_memory_for_cache_pkg::*;

   localparam int DEPTH_WORDS = 1024;
   localparam int LINE_BYTES  = 32;
   localparam int NUM_LINES   = DEPTH_WORDS / WORDS_PER_LINE;

   typedef struct {
      string name;
      line_t line;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        write_enable = 1'b0;
   logic [31:0] address = '0;
   word_t       write_data = '0;
   byte_mask_t  write_mask = '0;
   line_t       read_data;

   exp_t exp_q[$];
   logic check_strobe = 1'b0;
   int   checks = 0;
   int   errors = 0;

   data_memory_for_cache #(.DEPTH_WORDS(DEPTH_WORDS)) dut (
      .clk          (clk),
      .reset        (reset),
      .write_enable (write_enable),
      .address      (address),
      .write_data   (write_data),
      .write_mask   (write_mask),
      .read_data    (read_data)
   );

   always #5 clk = ~clk;

   // Monitor: the strobe marks the cycle in which read_data is the observed output.
   always @(negedge clk) begin
      if (check_strobe) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL no_expectation: read_data=%h with empty scoreboard", read_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (read_data !== e.line) begin
               errors++;
               $display("FAIL %s: got %h expected %h", e.name, read_data, e.line);
            end
         end
      end
   end

   task automatic expect_line(input logic [31:0] addr, input line_t line, input string name);
      address      = addr;
      write_enable = 1'b0;
      exp_q.push_back('{name: name, line: line});
      check_strobe = 1'b1;
      @(posedge clk);
      #1 check_strobe = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] addr, input word_t data, input byte_mask_t mask);
      address      = addr;
      write_data   = data;
      write_mask   = mask;
      write_enable = 1'b1;
      @(posedge clk);
      #1 write_enable = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      expect_line(32'd1, '0, "reset_addr1");
      expect_line(32'h0000_0FE0, '0, "reset_last_line");

      do_write(32'd1, 32'hDEADBEEF, 4'b1111);
      expect_line(32'd1, {224'h0, 32'hDEADBEEF}, "full_write");

      do_write(32'd1, 32'hCAFECAFE, 4'b1000);
      expect_line(32'd1, {224'h0, 32'hCAADBEEF}, "mask_1000");
      do_write(32'd1, 32'hCAFECAFE, 4'b0100);
      expect_line(32'd1, {224'h0, 32'hCAFEBEEF}, "mask_0100");
      do_write(32'd1, 32'hCAFECAFE, 4'b0010);
      expect_line(32'd1, {224'h0, 32'hCAFECAEF}, "mask_0010");
      do_write(32'd1, 32'hCAFECAFE, 4'b0001);
      expect_line(32'd1, {224'h0, 32'hCAFECAFE}, "mask_0001");

      do_write(32'd1, 32'hDEADBEEF, 4'b1100);
      expect_line(32'd1, {224'h0, 32'hDEADCAFE}, "mask_1100");
      do_write(32'd1, 32'hDEADBEEF, 4'b0011);
      expect_line(32'd1, {224'h0, 32'hDEADBEEF}, "mask_0011");

      do_write(32'd5, 32'h19721121, 4'b1100);
      expect_line(32'd5, {192'h0, 32'h19720000, 32'hDEADBEEF}, "word1_partial");
      expect_line(32'd3, {192'h0, 32'h19720000, 32'hDEADBEEF}, "low_bits_ignored");

      // Idle edges with live data on the bus must not write.
      address      = 32'd5;
      write_data   = 32'hDEADBEEF;
      write_mask   = 4'b1111;
      write_enable = 1'b0;
      repeat (2) @(posedge clk);
      #1 expect_line(32'd5, {192'h0, 32'h19720000, 32'hDEADBEEF}, "idle_no_write");

      do_write(32'd4, 32'hFFFFFFFF, 4'b0000);
      expect_line(32'd0, {192'h0, 32'h19720000, 32'hDEADBEEF}, "mask_0000");

      // Old data visible before the committing edge, new data right after it.
      address      = 32'd1;
      write_data   = 32'h11223344;
      write_mask   = 4'b1111;
      write_enable = 1'b1;
      exp_q.push_back('{name: "before_edge", line: {192'h0, 32'h19720000, 32'hDEADBEEF}});
      check_strobe = 1'b1;
      @(posedge clk);
      #1 check_strobe = 1'b0;
      write_enable = 1'b0;
      expect_line(32'd1, {192'h0, 32'h19720000, 32'h11223344}, "after_edge");

      do_write(32'd32, 32'hA5A5A5A5, 4'b1111);
      do_write(32'd60, 32'h0BADF00D, 4'b1111);
      expect_line(32'd0, {192'h0, 32'h19720000, 32'h11223344}, "line0_untouched");
      expect_line(32'd32, {32'h0BADF00D, 192'h0, 32'hA5A5A5A5}, "line1");
      expect_line(32'(LINE_BYTES + LINE_BYTES * NUM_LINES),
                  {32'h0BADF00D, 192'h0, 32'hA5A5A5A5}, "line1_wrap");

      // Reset wins over a simultaneous write.
      address      = 32'd0;
      write_data   = 32'hFFFFFFFF;
      write_mask   = 4'b1111;
      write_enable = 1'b1;
      reset        = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      write_enable = 1'b0;
      expect_line(32'd0, '0, "reset_prio_line0");
      expect_line(32'd32, '0, "reset_prio_line1");

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, 0 required", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
